// File: rtl/sram_ctrl_pkg.sv
// Shared types and sizes for the 16b x 32K SRAM bank controller.
// Imported by the arbiter and the bank controller top.
package sram_ctrl_pkg;
  localparam int SRAM_AW    = 15;
  localparam int SRAM_DW    = 16;
  localparam int SRAM_DEPTH = 32768;

  typedef enum logic {
    S_CLEAR,
    S_SERVE
  } ctrl_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, searching upward from ptr+1.
// Pointer moves to the winner only when a grant is issued.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] idx;
  logic [PW-1:0] win;
  logic          hit;

  always_comb begin
    gnt = '0;
    win = ptr;
    hit = 1'b0;
    idx = '0;
    for (int k = 1; k <= N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (en && !hit && req[idx]) begin
        gnt[idx] = 1'b1;
        win      = idx;
        hit      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= PW'(N - 1);
    else if (hit)
      ptr <= win;
  end
endmodule

// File: rtl/sram_bank_ctrl.sv
// Single-port SRAM bank controller: optional zero-fill after reset,
// then round-robin shared access with tagged 2-edge read responses.
module sram_bank_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter bit CLEAR_EN = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ-1:0]           req_we,
  input  logic [N_REQ*SRAM_AW-1:0]   req_addr,
  input  logic [N_REQ*SRAM_DW-1:0]   req_wdata,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic [SRAM_DW-1:0]         rsp_rdata,
  output logic                       init_busy,
  output logic                       sram_cs,
  output logic                       sram_oe,
  output logic                       sram_web,
  output logic [SRAM_AW-1:0]         sram_a,
  output logic [SRAM_DW-1:0]         sram_di,
  input  logic [SRAM_DW-1:0]         sram_do
);
  ctrl_state_e state;

  logic [SRAM_AW-1:0] clr_cnt;
  logic [SRAM_AW-1:0] a_q;
  logic [SRAM_DW-1:0] di_q;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   rd_pend;
  logic               arb_en;
  logic               g_we;
  logic [SRAM_AW-1:0] g_addr;
  logic [SRAM_DW-1:0] g_wdata;

  assign arb_en    = rst_n && (state == S_SERVE);
  assign init_busy = rst_n && (state == S_CLEAR);
  assign req_ready = gnt;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (arb_en),
    .req   (req_valid),
    .gnt   (gnt)
  );

  always_comb begin
    g_we    = 1'b0;
    g_addr  = '0;
    g_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        g_we    = req_we[i];
        g_addr  = req_addr[SRAM_AW*i +: SRAM_AW];
        g_wdata = req_wdata[SRAM_DW*i +: SRAM_DW];
      end
    end
  end

  // Idle cycles keep address/data stable to avoid needless pin toggling.
  always_comb begin
    sram_cs  = 1'b0;
    sram_web = 1'b1;
    sram_a   = a_q;
    sram_di  = di_q;
    unique case (1'b1)
      !rst_n: begin
        sram_a  = '0;
        sram_di = '0;
      end
      init_busy: begin
        sram_cs  = 1'b1;
        sram_web = 1'b0;
        sram_a   = clr_cnt;
        sram_di  = '0;
      end
      (|gnt): begin
        sram_cs  = 1'b1;
        sram_web = ~g_we;
        sram_a   = g_addr;
        sram_di  = g_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CLEAR_EN ? S_CLEAR : S_SERVE;
      clr_cnt   <= '0;
      a_q       <= '0;
      di_q      <= '0;
      rd_pend   <= '0;
      sram_oe   <= 1'b0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      a_q  <= sram_a;
      di_q <= sram_di;
      if (state == S_CLEAR) begin
        if (clr_cnt == SRAM_AW'(SRAM_DEPTH - 1))
          state <= S_SERVE;
        else
          clr_cnt <= clr_cnt + 1'b1;
      end
      rd_pend   <= g_we ? '0 : gnt;
      sram_oe   <= (|gnt) && !g_we;
      rsp_valid <= rd_pend;
      if (|rd_pend)
        rsp_rdata <= sram_do;
    end
  end
endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Directed bench for sram_bank_ctrl with a behavioural SRAM model.
// Expected values are hand-computed per scenario.
module tb_sram_bank_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [29:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic [15:0] rsp_rdata;
  logic        init_busy;
  logic        sram_cs;
  logic        sram_oe;
  logic        sram_web;
  logic [14:0] sram_a;
  logic [15:0] sram_di;
  logic [15:0] sram_do;

  logic [15:0] mem [0:32767];
  logic [15:0] q;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sram_bank_ctrl #(.N_REQ(2), .CLEAR_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .init_busy (init_busy),
    .sram_cs   (sram_cs),
    .sram_oe   (sram_oe),
    .sram_web  (sram_web),
    .sram_a    (sram_a),
    .sram_di   (sram_di),
    .sram_do   (sram_do)
  );

  initial begin
    for (int i = 0; i < 32768; i++)
      mem[i] <= 16'h5A5A;
    q <= 16'h0;
  end

  always @(posedge clk) begin
    if (sram_cs) begin
      if (!sram_web)
        mem[sram_a] <= sram_di;
      else
        q <= mem[sram_a];
    end
  end

  assign sram_do = sram_oe ? q : 16'hDEAD;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int i, input logic v, input logic we,
                       input logic [14:0] a, input logic [15:0] d);
    req_valid[i]         = v;
    req_we[i]            = we;
    req_addr[15*i +: 15] = a;
    req_wdata[16*i +: 16] = d;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  int         cnt;
  logic       rdy_seen;
  logic [1:0] exp_g [4];
  logic [15:0] exp_d [4];

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_d = '{16'h1234, 16'hA5A5, 16'h1234, 16'hA5A5};
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(init_busy), 0);
    check("rst_cs", 32'(sram_cs), 0);
    check("rst_web", 32'(sram_web), 1);
    check("rst_rsp", 32'(rsp_valid), 0);

    drive(0, 1'b1, 1'b0, 15'h7FFF, 16'h0);
    drive(1, 1'b1, 1'b1, 15'h0001, 16'h1111);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("clr_a0", 32'(sram_a), 0);
    check("clr_cs", 32'(sram_cs), 1);
    check("clr_web", 32'(sram_web), 0);
    cnt = 0;
    rdy_seen = 1'b0;
    while (init_busy && cnt < 40000) begin
      cnt++;
      if (req_ready != 2'b00) rdy_seen = 1'b1;
      step();
    end
    check("clr_cycles", 32'(cnt), 32768);
    check("clr_ready", 32'(rdy_seen), 0);

    drive(1, 1'b0, 1'b0, 15'h0, 16'h0);
    #1;
    check("t1_gnt", 32'(req_ready), 1);
    step();
    drive(0, 1'b0, 1'b0, 15'h0, 16'h0);
    check("t1_oe", 32'(sram_oe), 1);
    step();
    check("t1_rsp", 32'(rsp_valid), 1);
    check("t1_dat", 32'(rsp_rdata), 0);

    step();
    drive(0, 1'b1, 1'b1, 15'h0005, 16'h1234);
    #1;
    check("t2_wgnt", 32'(req_ready), 1);
    check("t2_wweb", 32'(sram_web), 0);
    check("t2_wa", 32'(sram_a), 5);
    check("t2_wdi", 32'(sram_di), 32'h1234);
    step();
    drive(0, 1'b1, 1'b0, 15'h0005, 16'h0);
    #1;
    check("t2_rweb", 32'(sram_web), 1);
    check("t2_rcs", 32'(sram_cs), 1);
    step();
    drive(0, 1'b0, 1'b0, 15'h0, 16'h0);
    check("t2_oe", 32'(sram_oe), 1);
    check("t2_early", 32'(rsp_valid), 0);
    step();
    check("t2_rsp", 32'(rsp_valid), 1);
    check("t2_dat", 32'(rsp_rdata), 32'h1234);
    step();
    check("t2_pulse", 32'(rsp_valid), 0);

    drive(1, 1'b1, 1'b1, 15'h0010, 16'hA5A5);
    #1;
    check("t2b_gnt", 32'(req_ready), 2);
    step();
    drive(1, 1'b0, 1'b0, 15'h0, 16'h0);
    step();
    check("wr_norsp", 32'(rsp_valid), 0);

    drive(0, 1'b1, 1'b0, 15'h0005, 16'h0);
    drive(1, 1'b1, 1'b0, 15'h0010, 16'h0);
    for (int c = 0; c < 6; c++) begin
      if (c == 4) req_valid = 2'b00;
      #1;
      check("t3_gnt", 32'(req_ready), (c < 4) ? 32'(exp_g[c]) : 0);
      step();
      if (c >= 1 && c <= 4) begin
        check("t3_rsp", 32'(rsp_valid), 32'(exp_g[c-1]));
        check("t3_dat", 32'(rsp_rdata), 32'(exp_d[c-1]));
      end else begin
        check("t3_rsp", 32'(rsp_valid), 0);
      end
    end

    drive(0, 1'b1, 1'b0, 15'h4000, 16'h0);
    drive(1, 1'b1, 1'b1, 15'h4000, 16'hBEEF);
    #1;
    check("t4_rdwin", 32'(req_ready), 1);
    check("t4_rweb", 32'(sram_web), 1);
    step();
    drive(0, 1'b0, 1'b0, 15'h0, 16'h0);
    #1;
    check("t4_wgnt", 32'(req_ready), 2);
    check("t4_wweb", 32'(sram_web), 0);
    check("t4_wa", 32'(sram_a), 32'h4000);
    check("t4_wdi", 32'(sram_di), 32'hBEEF);
    step();
    drive(1, 1'b0, 1'b0, 15'h0, 16'h0);
    check("t4_rsp", 32'(rsp_valid), 1);
    check("t4_old", 32'(rsp_rdata), 0);

    for (int i = 0; i < 3; i++) begin
      #1;
      check("t6_cs", 32'(sram_cs), 0);
      check("t6_web", 32'(sram_web), 1);
      check("t6_a", 32'(sram_a), 32'h4000);
      check("t6_di", 32'(sram_di), 32'hBEEF);
      step();
    end
    drive(0, 1'b1, 1'b0, 15'h4000, 16'h0);
    drive(1, 1'b1, 1'b0, 15'h0010, 16'h0);
    #1;
    check("t6_ptr", 32'(req_ready), 1);
    step();
    drive(0, 1'b0, 1'b0, 15'h0, 16'h0);
    #1;
    check("t6_next", 32'(req_ready), 2);
    step();
    drive(1, 1'b0, 1'b0, 15'h0, 16'h0);
    check("t4_rsp2", 32'(rsp_valid), 1);
    check("t4_new", 32'(rsp_rdata), 32'hBEEF);
    step();
    check("t6_rsp", 32'(rsp_valid), 2);
    check("t6_dat", 32'(rsp_rdata), 32'hA5A5);

    drive(0, 1'b1, 1'b0, 15'h0005, 16'h0);
    step();
    drive(0, 1'b0, 1'b0, 15'h0, 16'h0);
    check("t5_oe", 32'(sram_oe), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rsp", 32'(rsp_valid), 0);
    check("t5_oe0", 32'(sram_oe), 0);
    check("t5_cs", 32'(sram_cs), 0);
    check("t5_web", 32'(sram_web), 1);
    check("t5_busy", 32'(init_busy), 0);
    step();
    check("t5_drop", 32'(rsp_valid), 0);
    #2;
    rst_n = 1'b1;
    #1;
    check("t5_rbusy", 32'(init_busy), 1);
    check("t5_ra0", 32'(sram_a), 0);
    check("t5_rcs", 32'(sram_cs), 1);
    check("t5_rweb", 32'(sram_web), 0);
    step();
    check("t5_ra1", 32'(sram_a), 1);
    check("t5_nrsp", 32'(rsp_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule
